// File: rtl/secded_scrub_pkg.sv
// Shared types and constants for the inverted Hamming(22,16) memory scrubber.
package secded_scrub_pkg;

  localparam int CodeWidth = 22;
  localparam int DataWidth = 16;

  // Check bits 17, 19 and 21 are stored inverted, so all-zero data encodes to this value.
  localparam logic [CodeWidth-1:0] InvMask = 22'h2a0000;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    NEXT
  } scrub_state_e;

endpackage

// File: rtl/prim_secded_inv_hamming_22_16_dec.sv
// Inverted Hamming(22,16) decoder: corrects single-bit errors, flags double-bit errors.
// err_o[0] = correctable (odd overall parity), err_o[1] = uncorrectable.
module prim_secded_inv_hamming_22_16_dec
  import secded_scrub_pkg::*;
(
  input  logic [CodeWidth-1:0] data_i,
  output logic [DataWidth-1:0] data_o,
  output logic [1:0]           err_o
);

  localparam logic [CodeWidth-1:0] Mask0 = 22'h01ad5b;
  localparam logic [CodeWidth-1:0] Mask1 = 22'h02366d;
  localparam logic [CodeWidth-1:0] Mask2 = 22'h04c78e;
  localparam logic [CodeWidth-1:0] Mask3 = 22'h0807f0;
  localparam logic [CodeWidth-1:0] Mask4 = 22'h10f800;
  localparam logic [CodeWidth-1:0] Mask5 = 22'h3fffff;

  logic [CodeWidth-1:0] raw;
  logic [5:0]           syn;

  always_comb begin
    raw    = data_i ^ InvMask;
    syn[0] = ^(raw & Mask0);
    syn[1] = ^(raw & Mask1);
    syn[2] = ^(raw & Mask2);
    syn[3] = ^(raw & Mask3);
    syn[4] = ^(raw & Mask4);
    syn[5] = ^(raw & Mask5);
    data_o = raw[DataWidth-1:0];
    // A data bit is flipped when the syndrome equals that bit's parity-check column.
    for (int i = 0; i < DataWidth; i++) begin
      data_o[i] = raw[i] ^ (syn == {1'b1, Mask4[i], Mask3[i], Mask2[i], Mask1[i], Mask0[i]});
    end
    err_o[0] = syn[5];
    err_o[1] = (|syn[4:0]) & ~syn[5];
  end

endmodule

// File: rtl/prim_secded_inv_hamming_22_16_enc.sv
// Inverted Hamming(22,16) encoder: five Hamming check bits plus overall parity,
// with the InvMask bits flipped on the way out.
module prim_secded_inv_hamming_22_16_enc
  import secded_scrub_pkg::*;
(
  input  logic [DataWidth-1:0] data_i,
  output logic [CodeWidth-1:0] data_o
);

  logic [CodeWidth-1:0] cw;

  always_comb begin
    cw     = CodeWidth'(data_i);
    cw[16] = ^(cw & 22'h00ad5b);
    cw[17] = ^(cw & 22'h00366d);
    cw[18] = ^(cw & 22'h00c78e);
    cw[19] = ^(cw & 22'h0007f0);
    cw[20] = ^(cw & 22'h00f800);
    // Overall parity covers the check bits just computed.
    cw[21] = ^(cw & 22'h3fffff);
    data_o = cw ^ InvMask;
  end

endmodule

// File: rtl/secded_inv_22_16_scrubber.sv
// Background scrubber: walks the memory, corrects single-bit errors by write-back
// and keeps saturating counts of correctable/uncorrectable words.
module secded_inv_22_16_scrubber
  import secded_scrub_pkg::*;
#(
  parameter int Depth     = 1024,
  parameter int AddrWidth = 10,
  parameter int Interval  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 clear_i,
  output logic                 req_o,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [CodeWidth-1:0] wdata_o,
  input  logic                 gnt_i,
  input  logic                 rvalid_i,
  input  logic [CodeWidth-1:0] rdata_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          corr_cnt_o,
  output logic [15:0]          uncorr_cnt_o,
  output logic                 uncorr_valid_o,
  output logic [AddrWidth-1:0] uncorr_addr_o,
  output logic [2:0]           state_o
);

  // Handshake: a request (req_o, we_o, addr_o, wdata_o) is driven straight from
  // state registers and held until a cycle with req_o && gnt_i; that edge is the
  // transfer. Read data is accepted only in RD_WAIT on rvalid_i; one request in flight.

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);
  localparam int                   GapWidth = $clog2(Interval + 2);
  localparam logic [GapWidth-1:0]  GapLast  = GapWidth'((Interval > 0) ? Interval - 1 : 0);

  scrub_state_e           state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [GapWidth-1:0]    gap_q, gap_d;
  logic [DataWidth-1:0]   data_q, dec_data;
  logic [1:0]             dec_err;
  logic [15:0]            corr_cnt_q, uncorr_cnt_q;
  logic                   uncorr_valid_q;
  logic [AddrWidth-1:0]   uncorr_addr_q;
  logic                   rsp_fire;

  prim_secded_inv_hamming_22_16_dec u_dec (
    .data_i (rdata_i),
    .data_o (dec_data),
    .err_o  (dec_err)
  );

  prim_secded_inv_hamming_22_16_enc u_enc (
    .data_i (data_q),
    .data_o (wdata_o)
  );

  assign rsp_fire = (state_q == RD_WAIT) && rvalid_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        if (enable_i) state_d = RD_REQ;
      end
      GAP: begin
        if (gap_q == GapLast) state_d = RD_REQ;
        else                  gap_d   = gap_q + 1'b1;
      end
      RD_REQ:  if (gnt_i) state_d = RD_WAIT;
      RD_WAIT: if (rvalid_i) state_d = dec_err[0] ? WR_REQ : NEXT;
      WR_REQ:  if (gnt_i) state_d = NEXT;
      NEXT: begin
        addr_d = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
        gap_d  = '0;
        if (!enable_i) begin
          state_d = IDLE;
          addr_d  = '0;
        end else if (Interval > 0) begin
          state_d = GAP;
        end else begin
          state_d = RD_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      gap_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
      if (rsp_fire) data_q <= dec_data;
    end
  end

  // clear_i wins over any increment or capture in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      corr_cnt_q     <= '0;
      uncorr_cnt_q   <= '0;
      uncorr_valid_q <= 1'b0;
      uncorr_addr_q  <= '0;
    end else if (clear_i) begin
      corr_cnt_q     <= '0;
      uncorr_cnt_q   <= '0;
      uncorr_valid_q <= 1'b0;
      uncorr_addr_q  <= '0;
    end else if (rsp_fire) begin
      if (dec_err[0] && (corr_cnt_q != 16'hffff)) corr_cnt_q <= corr_cnt_q + 16'd1;
      if (dec_err[1]) begin
        if (uncorr_cnt_q != 16'hffff) uncorr_cnt_q <= uncorr_cnt_q + 16'd1;
        if (!uncorr_valid_q) begin
          uncorr_valid_q <= 1'b1;
          uncorr_addr_q  <= addr_q;
        end
      end
    end
  end

  assign req_o          = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign we_o           = (state_q == WR_REQ);
  assign addr_o         = addr_q;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == NEXT) && (addr_q == LastAddr);
  assign corr_cnt_o     = corr_cnt_q;
  assign uncorr_cnt_o   = uncorr_cnt_q;
  assign uncorr_valid_o = uncorr_valid_q;
  assign uncorr_addr_o  = uncorr_addr_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_secded_inv_22_16_scrubber.sv
// Bench for the scrubber: a 4-word memory responder with stalls and latency, and a
// pass-level model that predicts every memory transaction and the error accounting.
module tb_secded_inv_22_16_scrubber;

  localparam int D  = 4;
  localparam int AW = 10;
  localparam int TW = 1 + AW + 22;
  // Parity-check column of each data bit (bit 5 = overall parity).
  localparam logic [5:0] COLS [16] = '{6'h23, 6'h25, 6'h26, 6'h27, 6'h29, 6'h2a, 6'h2b, 6'h2c,
                                       6'h2d, 6'h2e, 6'h2f, 6'h31, 6'h32, 6'h33, 6'h34, 6'h35};

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          enable_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          req_o, we_o;
  logic [AW-1:0] addr_o;
  logic [21:0]   wdata_o;
  logic          gnt_i = 1'b0;
  logic          rvalid_i = 1'b0;
  logic [21:0]   rdata_i = 22'h0;
  logic          busy_o, done_o;
  logic [15:0]   corr_cnt_o, uncorr_cnt_o;
  logic          uncorr_valid_o;
  logic [AW-1:0] uncorr_addr_o;
  logic [2:0]    state_o;

  secded_inv_22_16_scrubber #(.Depth(D), .AddrWidth(AW), .Interval(0)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable_i),
    .clear_i        (clear_i),
    .req_o          (req_o),
    .we_o           (we_o),
    .addr_o         (addr_o),
    .wdata_o        (wdata_o),
    .gnt_i          (gnt_i),
    .rvalid_i       (rvalid_i),
    .rdata_i        (rdata_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .corr_cnt_o     (corr_cnt_o),
    .uncorr_cnt_o   (uncorr_cnt_o),
    .uncorr_valid_o (uncorr_valid_o),
    .uncorr_addr_o  (uncorr_addr_o),
    .state_o        (state_o)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [TW-1:0] exp_q[$];
  logic [21:0]   mem [D];
  logic [15:0]   mdata [D];
  int            flips [D];
  logic [15:0]   exp_corr = 16'h0;
  logic [15:0]   exp_uncorr = 16'h0;
  logic          exp_uv = 1'b0;
  int            exp_ua = 0;

  function automatic logic [21:0] ref_enc(input logic [15:0] d);
    logic [21:0] c;
    c = {6'h0, d};
    for (int i = 0; i < 16; i++) if (d[i]) c[20:16] = c[20:16] ^ COLS[i][4:0];
    c[21] = ^c[20:0];
    return c ^ 22'h2a0000;
  endfunction

  function automatic logic [21:0] rand_mask();
    logic [21:0] m;
    int nf, b0, b1;
    m = 22'h0;
    nf = $urandom_range(0, 2);
    b0 = $urandom_range(0, 21);
    b1 = (b0 + $urandom_range(1, 21)) % 22;
    if (nf >= 1) m[b0] = 1'b1;
    if (nf == 2) m[b1] = 1'b1;
    return m;
  endfunction

  task automatic load_word(input int a, input logic [15:0] d, input logic [21:0] m);
    mdata[a] = d;
    flips[a] = $countones(m);
    mem[a]   = ref_enc(d) ^ m;
  endtask

  // One full pass in address order; clr is the address whose response coincides with clear_i.
  task automatic model_pass(input int clr);
    for (int a = 0; a < D; a++) begin
      exp_q.push_back({1'b0, AW'(a), 22'h0});
      if (a == clr) begin
        exp_corr = 16'h0; exp_uncorr = 16'h0; exp_uv = 1'b0; exp_ua = 0;
      end
      if (flips[a] == 1) begin
        exp_q.push_back({1'b1, AW'(a), ref_enc(mdata[a])});
        if (a != clr && exp_corr != 16'hffff) exp_corr++;
        flips[a] = 0;
      end else if (flips[a] == 2 && a != clr) begin
        if (exp_uncorr != 16'hffff) exp_uncorr++;
        if (!exp_uv) begin exp_uv = 1'b1; exp_ua = a; end
      end
    end
  endtask

  // memory responder / transaction scoreboard
  int rd_stall = 0, wr_stall = 0, rsp_lat = 0;
  bit noise = 1'b0;
  int clear_addr = -1;
  int clear_req = 0, clear_ack = 0;
  bit pend = 1'b0, in_req = 1'b0;
  int pend_addr = 0, lat_left = 0, stall_left = 0;
  logic [TW-1:0] txn;

  always @(negedge clk) begin
    if (!rst_n) begin
      gnt_i = 1'b0; rvalid_i = 1'b0; clear_i = 1'b0; pend = 1'b0; in_req = 1'b0;
    end else begin
      gnt_i = 1'b0; rvalid_i = 1'b0; clear_i = 1'b0;
      if (clear_req != clear_ack) begin clear_i = 1'b1; clear_ack = clear_req; end
      if (pend) begin
        if (lat_left == 0) begin
          rvalid_i = 1'b1; rdata_i = mem[pend_addr]; pend = 1'b0;
          if (pend_addr == clear_addr) clear_i = 1'b1;
        end else lat_left--;
      end else if (noise && $urandom_range(0, 7) == 0) begin
        rvalid_i = 1'b1; rdata_i = 22'h2a0003;
      end
      if (req_o) begin
        txn = {we_o, addr_o, we_o ? wdata_o : 22'h0};
        if (!in_req) begin
          in_req = 1'b1;
          stall_left = we_o ? wr_stall : rd_stall;
          if (stall_left < 0) stall_left = $urandom_range(0, 3);
        end
        check("txn_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("txn", txn, exp_q[0]);
        if (stall_left > 0) stall_left--;
        else begin
          gnt_i = 1'b1; in_req = 1'b0;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          if (we_o) begin
            if (int'(addr_o) < D) mem[addr_o] = wdata_o;
          end else begin
            pend = 1'b1; pend_addr = int'(addr_o);
            lat_left = (rsp_lat < 0) ? $urandom_range(0, 2) : rsp_lat;
          end
        end
      end else if (noise && $urandom_range(0, 5) == 0) begin
        gnt_i = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic run_passes(input int n);
    int seen = 0;
    int cyc = 0;
    enable_i = 1'b1;
    while (seen < n && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (done_o) begin
        seen++;
        if (seen == n) enable_i = 1'b0;
      end
    end
    enable_i = 1'b0;
    check("passes_done", seen, n);
    cyc = 0;
    while (busy_o && cyc < 100) begin @(negedge clk); cyc++; end
    check("idle_after_pass", busy_o, 1'b0);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_corr"}, corr_cnt_o, exp_corr);
    check({tag, "_uncorr"}, uncorr_cnt_o, exp_uncorr);
    check({tag, "_uvalid"}, uncorr_valid_o, exp_uv);
    check({tag, "_uaddr"}, uncorr_addr_o, AW'(exp_ua));
    check({tag, "_txn_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    for (int a = 0; a < D; a++) load_word(a, 16'h0, 22'h0);
    repeat (2) @(negedge clk);
    check("rst_req_held", req_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req", req_o, 1'b0);
    check("rst_we", we_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_addr", addr_o, 0);
    check("rst_wdata", wdata_o, 22'h2a0000);
    check_status("rst");

    // clean memory, two passes
    model_pass(-1); model_pass(-1);
    run_passes(2);
    check_status("clean");

    // single data-bit error at word 2, corrected once
    load_word(2, 16'h0, 22'h000001);
    model_pass(-1); model_pass(-1);
    run_passes(2);
    check_status("single");
    check("single_mem_fixed", mem[2], 22'h2a0000);

    // double error at word 1, then another at word 3
    load_word(1, 16'h0, 22'h000003);
    model_pass(-1);
    run_passes(1);
    check_status("double1");
    load_word(1, 16'h0, 22'h0);
    load_word(3, 16'h0, 22'h000210);
    model_pass(-1);
    run_passes(1);
    check_status("double3");

    // 5-cycle grant stalls on read and write
    rd_stall = 5; wr_stall = 5;
    load_word(3, 16'($urandom), 22'h0);
    load_word(0, 16'($urandom), 22'h1 << $urandom_range(0, 21));
    model_pass(-1);
    run_passes(1);
    check_status("stall");
    rd_stall = 0; wr_stall = 0;

    // enable dropped in RD_WAIT of a correctable word
    rsp_lat = 3;
    load_word(0, 16'($urandom), 22'h1 << $urandom_range(0, 21));
    exp_q.push_back({1'b0, AW'(0), 22'h0});
    exp_q.push_back({1'b1, AW'(0), ref_enc(mdata[0])});
    exp_corr++; flips[0] = 0;
    enable_i = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(busy_o && !req_o) && cyc < 50);
    check("drop_reached_wait", busy_o && !req_o, 1'b1);
    enable_i = 1'b0;
    cyc = 0;
    while (busy_o && cyc < 100) begin @(negedge clk); cyc++; end
    check("drop_idle", busy_o, 1'b0);
    check_status("drop");
    rsp_lat = 0;
    model_pass(-1);
    run_passes(1);
    check_status("reenable");

    // clear while idle, then clear coinciding with a counted response
    clear_req++;
    repeat (3) @(negedge clk);
    exp_corr = 16'h0; exp_uncorr = 16'h0; exp_uv = 1'b0; exp_ua = 0;
    check_status("clear_idle");
    load_word(1, 16'h0, 22'h000003);
    load_word(2, 16'($urandom), 22'h1 << $urandom_range(0, 21));
    clear_addr = 2;
    model_pass(2);
    run_passes(1);
    clear_addr = -1;
    check_status("clear_same");
    load_word(1, 16'h0, 22'h0);
    load_word(3, 16'($urandom), 22'h000003 << $urandom_range(0, 20));
    clear_addr = 3;
    model_pass(3);
    run_passes(1);
    clear_addr = -1;
    check_status("clear_uncorr");

    // correctable counter saturation
    force dut.corr_cnt_q = 16'hffff;
    @(negedge clk);
    release dut.corr_cnt_q;
    @(negedge clk);
    exp_corr = 16'hffff;
    check("sat_preload", corr_cnt_o, 16'hffff);
    load_word(0, 16'($urandom), 22'h1 << $urandom_range(0, 21));
    model_pass(-1);
    run_passes(1);
    check_status("sat");

    // randomized rounds with stalls, latency and ignored stray strobes
    noise = 1'b1; rd_stall = -1; wr_stall = -1; rsp_lat = -1;
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < D; a++) load_word(a, 16'($urandom), rand_mask());
      model_pass(-1); model_pass(-1);
      run_passes(2);
      check_status("rand");
    end
    noise = 1'b0; rd_stall = 0; rsp_lat = 0;

    // asynchronous reset during a stalled write-back
    wr_stall = 5;
    for (int a = 0; a < D; a++) load_word(a, 16'h0, 22'h0);
    load_word(0, 16'($urandom), 22'h000100);
    exp_q.push_back({1'b0, AW'(0), 22'h0});
    exp_q.push_back({1'b1, AW'(0), ref_enc(mdata[0])});
    enable_i = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(req_o && we_o) && cyc < 50);
    check("arst_in_write", req_o && we_o, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", req_o, 1'b0);
    check("arst_busy", busy_o, 1'b0);
    check("arst_corr", corr_cnt_o, 16'h0);
    enable_i = 1'b0;
    exp_q.delete();
    exp_corr = 16'h0; exp_uncorr = 16'h0; exp_uv = 1'b0; exp_ua = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("arst_no_write", mem[0], ref_enc(mdata[0]) ^ 22'h000100);
    check("arst_wdata", wdata_o, 22'h2a0000);
    check_status("arst");
    wr_stall = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
